mem_port_arbiter: RTL and testbench

Shares one single-ported memory between the CPU's instruction-fetch requester (IFetch stage) and data requester (LW/SW in the Memory stage). It accepts level-held requests, arbitrates with data priority plus an anti-starvation limit for instruction fetch, and issues one memory access at a time. It pulses a per-port acknowledge, and for reads it returns the data when the fixed-latency memory responds.

---
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between fetch and data requesters
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,
  parameter int D_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [3:0] cnt, streak;
  logic win_d, is_st, grant_d;
  // data wins unless fetch has already waited through D_STREAK data grants
  assign grant_d = d_req && !(i_req && streak == 4'(D_STREAK));
  // single transaction FSM: sample in IDLE, strobe memory for one cycle, then wait out the fixed latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      win_d     <= 1'b0;
      is_st     <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: if (i_req || d_req) begin
          state     <= ISSUE;
          win_d     <= grant_d;
          is_st     <= grant_d && d_we;
          mem_en    <= 1'b1;
          mem_we    <= grant_d && d_we;
          mem_addr  <= grant_d ? d_addr : i_addr;
          mem_wdata <= d_wdata;
          streak    <= (grant_d && i_req) ? streak + 4'(streak != 4'(D_STREAK)) : 4'd0;
        end
        ISSUE: begin
          state  <= WAIT;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= 4'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            d_ack <= win_d;
            i_ack <= !win_d;
            if (win_d && !is_st) d_rdata <= mem_rdata;
            if (!win_d) i_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector, corner-case and randomized checks of the memory port arbiter
module tb_mem_port_arbiter;
  localparam int AW = 10, DW = 32, LAT = 3, DS = 4;
  logic clk = 0, reset = 0;
  logic i_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = 32'h5A5A_5A5A;
  logic i_ack, d_ack, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  int n_chk = 0, n_fail = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .D_STREAK(DS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory contents: written words, otherwise a fixed address-derived pattern
  logic [DW-1:0] mem [1<<AW];
  bit wr [1<<AW];
  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return wr[a] ? mem[a] : (a == 10'h010 ? 32'h2008_0005 : (32'hA500_0000 | 32'(a)));
  endfunction

  // memory: data valid only in the cycle ending LAT edges after the sampling edge, garbage otherwise
  int rem = 0;
  logic [AW-1:0] ra = '0;
  always @(posedge clk) begin
    mem_rdata <= 32'h5A5A_5A5A;
    if (rem == 1) mem_rdata <= rd(ra);
    if (rem != 0) rem <= rem - 1;
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      if (LAT == 1) mem_rdata <= rd(mem_addr);
      else begin
        rem <= LAT - 1;
        ra <= mem_addr;
      end
    end
  end

  // reference: a busy flag plus edges elapsed since the grant decide every output
  logic m_busy = 0, m_d = 0, m_we = 0;
  int m_age = 0, m_streak = 0;
  logic [AW-1:0] m_addr = '0, e_addr = '0;
  logic e_i_ack = 0, e_d_ack = 0, e_en = 0, e_we = 0;
  logic [DW-1:0] e_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;
  function automatic logic pick_d(input logic ir, input logic dr, input int s);
    return dr && !(ir && s == DS);
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_age <= 0; m_streak <= 0;
      e_i_ack <= 0; e_d_ack <= 0; e_en <= 0; e_we <= 0;
      e_addr <= '0; e_wdata <= '0; e_i_rdata <= '0; e_d_rdata <= '0;
    end else begin
      e_i_ack <= 0;
      e_d_ack <= 0;
      if (m_busy) begin
        m_age <= m_age + 1;
        if (m_age == 0) begin
          e_en <= 0;
          e_we <= 0;
        end
        if (m_age == LAT) begin
          m_busy <= 0;
          if (m_d) e_d_ack <= 1; else e_i_ack <= 1;
          if (m_d && !m_we) e_d_rdata <= rd(m_addr);
          if (!m_d) e_i_rdata <= rd(m_addr);
        end
      end else if (i_req || d_req) begin
        m_busy <= 1;
        m_age <= 0;
        m_d <= pick_d(i_req, d_req, m_streak);
        m_we <= pick_d(i_req, d_req, m_streak) && d_we;
        m_addr <= pick_d(i_req, d_req, m_streak) ? d_addr : i_addr;
        e_en <= 1;
        e_we <= pick_d(i_req, d_req, m_streak) && d_we;
        e_addr <= pick_d(i_req, d_req, m_streak) ? d_addr : i_addr;
        e_wdata <= d_wdata;
        m_streak <= (pick_d(i_req, d_req, m_streak) && i_req) ? (m_streak < DS ? m_streak + 1 : DS) : 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // advance one cycle and compare every output with the reference away from the active edge
  task automatic tick;
    @(negedge clk);
    chk("acks", {i_ack, d_ack}, {e_i_ack, e_d_ack});
    chk("mem_en_we", {mem_en, mem_we}, {e_en, e_we});
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_en && e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("i_rdata", i_rdata, e_i_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
  endtask

  task automatic wait_ack(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!(i_ack || d_ack) && c < 40);
    chk("ack_seen", i_ack || d_ack, 1);
  endtask

  typedef struct {
    logic ir; logic [AW-1:0] ia; logic dr; logic dwe; logic [AW-1:0] da; logic [DW-1:0] dwd;
    logic fd; logic [DW-1:0] r1; logic [DW-1:0] r2;
  } vec_t;
  vec_t vt [6];

  initial begin
    int c;
    vt[0] = '{1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h2008_0005, 32'h0};
    vt[1] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'h0};
    vt[2] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vt[3] = '{1'b1, 10'h011, 1'b1, 1'b0, 10'h012, 32'h0, 1'b1, 32'hA500_0012, 32'hA500_0011};
    vt[4] = '{1'b1, 10'h040, 1'b1, 1'b1, 10'h030, 32'hCAFE_F00D, 1'b1, 32'hA500_0012, 32'hA500_0040};
    vt[5] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h030, 32'h0, 1'b1, 32'hCAFE_F00D, 32'h0};
    #1 reset = 1;
    repeat (3) tick();
    reset = 0;
    repeat (5) begin
      tick();
      chk("idle_en", mem_en, 0);
    end
    for (int v = 0; v < 6; v++) begin
      i_req = vt[v].ir; i_addr = vt[v].ia;
      d_req = vt[v].dr; d_we = vt[v].dwe; d_addr = vt[v].da; d_wdata = vt[v].dwd;
      wait_ack(c);
      chk("lat1", c, LAT + 2);
      chk("port1", {i_ack, d_ack}, vt[v].fd ? 2'b01 : 2'b10);
      chk("data1", vt[v].fd ? d_rdata : i_rdata, vt[v].r1);
      if (vt[v].fd) d_req = 0; else i_req = 0;
      if (i_req || d_req) begin
        wait_ack(c);
        chk("lat2", c, LAT + 2);
        chk("port2", {i_ack, d_ack}, vt[v].fd ? 2'b10 : 2'b01);
        chk("data2", vt[v].fd ? i_rdata : d_rdata, vt[v].r2);
        i_req = 0;
        d_req = 0;
      end
      tick();
    end
    i_req = 1; i_addr = 10'h001; d_req = 1; d_we = 0; d_addr = 10'h002;
    for (int k = 0; k < 10; k++) begin
      wait_ack(c);
      chk("grant_order", d_ack, (k % 5) != 4);
    end
    i_req = 0;
    d_req = 0;
    tick();
    for (int n = 0; n < 400; n++) begin
      tick();
      if (i_ack || !i_req) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = AW'($urandom_range(0, 63));
      end
      if (d_ack || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = AW'($urandom_range(0, 63));
        d_wdata = $urandom;
      end
    end
    for (int n = 0; n < 30; n++) begin
      tick();
      if (i_ack) i_req = 0;
      if (d_ack) d_req = 0;
    end
    i_req = 0;
    d_req = 0;
    tick();
    i_req = 1; i_addr = 10'h050;
    c = 0;
    do begin
      tick();
      c++;
    end while (!mem_en && c < 20);
    chk("mem_en_seen", mem_en, 1);
    tick();
    tick();
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("rst_ctl", {i_ack, d_ack, mem_en, mem_we, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    tick();
    tick();
    reset = 0;
    wait_ack(c);
    chk("rst_relat", c, LAT + 2);
    chk("rst_port", {i_ack, d_ack}, 2'b10);
    chk("rst_data", i_rdata, 32'hA500_0050);
    i_req = 0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
